// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - CPU/DMA arbiter in front of a 68000-style SDRAM controller port
module sdram_port_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int GAP_CYCLES   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_ACCESS,
    input  logic        CPU_UDS,
    input  logic        CPU_LDS,
    input  logic        CPU_RW,
    input  logic [22:0] CPU_A,
    output logic        CPU_VALID,
    output logic        CPU_WTERM,
    input  logic        DMA_ACCESS,
    input  logic        DMA_UDS,
    input  logic        DMA_LDS,
    input  logic        DMA_RW,
    input  logic [22:0] DMA_A,
    output logic        DMA_VALID,
    output logic        DMA_WTERM,
    output logic        MEM_ACCESS,
    output logic        MEM_UDS,
    output logic        MEM_LDS,
    output logic        MEM_RW,
    output logic [22:0] MEM_A,
    input  logic        MEM_VALID,
    input  logic        MEM_WTERM,
    output logic [1:0]  GNT
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_CPU = 2'd1,
        GRANT_DMA = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_DMA  = 2'b10;
    localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);
    localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cpu_meta;
    logic [3:0]  cpu_sync;
    logic        cpu_access_s;
    logic        cpu_uds_s;
    logic        cpu_lds_s;
    logic        cpu_rw_s;
    logic [7:0]  wait_cnt;
    logic [1:0]  gap_cnt;
    logic        dma_starved;
    logic        own_access;
    logic        own_uds;
    logic        own_lds;
    logic        own_rw;
    logic        take_cpu;
    logic        take_dma;
    logic        release_now;
    logic        in_grant;

    // Two-flop synchroniser for the asynchronous CPU strobes {ACCESS, UDS, LDS, RW}
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cpu_meta <= 4'hF;
            cpu_sync <= 4'hF;
        end else begin
            cpu_meta <= {CPU_ACCESS, CPU_UDS, CPU_LDS, CPU_RW};
            cpu_sync <= cpu_meta;
        end
    end

    assign {cpu_access_s, cpu_uds_s, cpu_lds_s, cpu_rw_s} = cpu_sync;
    assign dma_starved = (wait_cnt == LIMIT);
    assign in_grant    = (state == GRANT_CPU) || (state == GRANT_DMA);

    // Select the current owner's strobes; idle-high when nobody owns the port
    always_comb begin
        own_access = 1'b1;
        own_uds    = 1'b1;
        own_lds    = 1'b1;
        own_rw     = 1'b1;
        case (state)
            GRANT_CPU: begin
                own_access = cpu_access_s;
                own_uds    = cpu_uds_s;
                own_lds    = cpu_lds_s;
                own_rw     = cpu_rw_s;
            end
            GRANT_DMA: begin
                own_access = DMA_ACCESS;
                own_uds    = DMA_UDS;
                own_lds    = DMA_LDS;
                own_rw     = DMA_RW;
            end
            default: begin
            end
        endcase
    end

    // Arbitration and grant lifecycle: next state plus one-cycle decision strobes
    always_comb begin
        state_nxt   = state;
        take_cpu    = 1'b0;
        take_dma    = 1'b0;
        release_now = 1'b0;
        case (state)
            IDLE: begin
                // CPU wins a tie unless the DMA port has waited long enough
                if (!cpu_access_s && (DMA_ACCESS || !dma_starved)) begin
                    take_cpu  = 1'b1;
                    state_nxt = GRANT_CPU;
                end else if (!DMA_ACCESS) begin
                    take_dma  = 1'b1;
                    state_nxt = GRANT_DMA;
                end
            end
            GRANT_CPU, GRANT_DMA: begin
                if (own_access) begin
                    release_now = 1'b1;
                    state_nxt   = RELEASE;
                end
            end
            RELEASE: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Release gap counter: keeps MEM_ACCESS high while the controller presets its latches
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gap_cnt <= 2'd0;
        end else if (release_now) begin
            gap_cnt <= 2'd0;
        end else if (state == RELEASE) begin
            gap_cnt <= gap_cnt + 2'd1;
        end
    end

    // DMA starvation counter: counts pending cycles without the grant, saturating
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wait_cnt <= 8'd0;
        end else if (take_dma || DMA_ACCESS) begin
            wait_cnt <= 8'd0;
        end else if ((GNT != GNT_DMA) && (wait_cnt < LIMIT)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Controller-side strobes, address, owner indication and acknowledge routing
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            MEM_ACCESS <= 1'b1;
            MEM_UDS    <= 1'b1;
            MEM_LDS    <= 1'b1;
            MEM_RW     <= 1'b1;
            MEM_A      <= 23'd0;
            GNT        <= GNT_NONE;
            CPU_VALID  <= 1'b1;
            CPU_WTERM  <= 1'b1;
            DMA_VALID  <= 1'b1;
            DMA_WTERM  <= 1'b1;
        end else if (take_cpu) begin
            MEM_A <= CPU_A;
            GNT   <= GNT_CPU;
        end else if (take_dma) begin
            MEM_A <= DMA_A;
            GNT   <= GNT_DMA;
        end else if (release_now) begin
            MEM_ACCESS <= 1'b1;
            MEM_UDS    <= 1'b1;
            MEM_LDS    <= 1'b1;
            MEM_RW     <= 1'b1;
            GNT        <= GNT_NONE;
            CPU_VALID  <= 1'b1;
            CPU_WTERM  <= 1'b1;
            DMA_VALID  <= 1'b1;
            DMA_WTERM  <= 1'b1;
        end else if (in_grant) begin
            // Strobes stay live for the whole grant since write strobes trail ACCESS
            MEM_ACCESS <= 1'b0;
            MEM_UDS    <= own_uds;
            MEM_LDS    <= own_lds;
            MEM_RW     <= own_rw;
            CPU_VALID  <= (state == GRANT_CPU) ? MEM_VALID : 1'b1;
            CPU_WTERM  <= (state == GRANT_CPU) ? MEM_WTERM : 1'b1;
            DMA_VALID  <= (state == GRANT_DMA) ? MEM_VALID : 1'b1;
            DMA_WTERM  <= (state == GRANT_DMA) ? MEM_WTERM : 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed plus randomized bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    localparam int STARVE_LIMIT = 8;
    localparam int GAP_CYCLES   = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CPU_ACCESS = 1'b1, CPU_UDS = 1'b1, CPU_LDS = 1'b1, CPU_RW = 1'b1;
    logic [22:0] CPU_A = 23'd0;
    logic        CPU_VALID, CPU_WTERM;
    logic        DMA_ACCESS = 1'b1, DMA_UDS = 1'b1, DMA_LDS = 1'b1, DMA_RW = 1'b1;
    logic [22:0] DMA_A = 23'd0;
    logic        DMA_VALID, DMA_WTERM;
    logic        MEM_ACCESS, MEM_UDS, MEM_LDS, MEM_RW;
    logic [22:0] MEM_A;
    logic        MEM_VALID = 1'b1, MEM_WTERM = 1'b1;
    logic [1:0]  GNT;

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the port, how many gap cycles remain, how long DMA has waited,
    // and what the CPU strobes looked like one and two edges ago (the synchroniser delay)
    int          m_owner;
    int          m_gap;
    int          m_wait;
    logic [3:0]  m_h0, m_h1;
    logic [1:0]  e_gnt;
    logic        e_acc, e_uds, e_lds, e_rw;
    logic [22:0] e_a;
    logic        e_cv, e_cw, e_dv, e_dw;

    sdram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .GAP_CYCLES(GAP_CYCLES)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_ACCESS(CPU_ACCESS), .CPU_UDS(CPU_UDS), .CPU_LDS(CPU_LDS), .CPU_RW(CPU_RW),
        .CPU_A(CPU_A), .CPU_VALID(CPU_VALID), .CPU_WTERM(CPU_WTERM),
        .DMA_ACCESS(DMA_ACCESS), .DMA_UDS(DMA_UDS), .DMA_LDS(DMA_LDS), .DMA_RW(DMA_RW),
        .DMA_A(DMA_A), .DMA_VALID(DMA_VALID), .DMA_WTERM(DMA_WTERM),
        .MEM_ACCESS(MEM_ACCESS), .MEM_UDS(MEM_UDS), .MEM_LDS(MEM_LDS), .MEM_RW(MEM_RW),
        .MEM_A(MEM_A), .MEM_VALID(MEM_VALID), .MEM_WTERM(MEM_WTERM), .GNT(GNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_owner = 0; m_gap = 0; m_wait = 0;
        m_h0 = 4'hF; m_h1 = 4'hF;
        e_gnt = 2'b00; e_acc = 1'b1; e_uds = 1'b1; e_lds = 1'b1; e_rw = 1'b1; e_a = 23'd0;
        e_cv = 1'b1; e_cw = 1'b1; e_dv = 1'b1; e_dw = 1'b1;
    endtask

    // Advance the model across one rising edge using the inputs currently applied
    task automatic model_edge();
        logic [3:0] cpu_now;
        logic [3:0] own;
        logic       cpu_req, dma_req;
        logic [1:0] gnt_before;
        int         chosen;
        cpu_now    = {CPU_ACCESS, CPU_UDS, CPU_LDS, CPU_RW};
        cpu_req    = !m_h1[3];
        dma_req    = !DMA_ACCESS;
        gnt_before = e_gnt;
        chosen     = 0;
        if (m_owner != 0) begin
            own = (m_owner == 1) ? m_h1 : {DMA_ACCESS, DMA_UDS, DMA_LDS, DMA_RW};
            if (own[3]) begin
                e_acc = 1'b1; e_uds = 1'b1; e_lds = 1'b1; e_rw = 1'b1; e_gnt = 2'b00;
                e_cv = 1'b1; e_cw = 1'b1; e_dv = 1'b1; e_dw = 1'b1;
                m_owner = 0;
                m_gap   = GAP_CYCLES;
            end else begin
                e_acc = 1'b0; e_uds = own[2]; e_lds = own[1]; e_rw = own[0];
                e_cv = (m_owner == 1) ? MEM_VALID : 1'b1;
                e_cw = (m_owner == 1) ? MEM_WTERM : 1'b1;
                e_dv = (m_owner == 2) ? MEM_VALID : 1'b1;
                e_dw = (m_owner == 2) ? MEM_WTERM : 1'b1;
            end
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end else if (cpu_req || dma_req) begin
            chosen  = (dma_req && (!cpu_req || m_wait == STARVE_LIMIT)) ? 2 : 1;
            m_owner = chosen;
            e_gnt   = 2'(chosen);
            e_a     = (chosen == 1) ? CPU_A : DMA_A;
        end
        if (chosen == 2 || !dma_req) m_wait = 0;
        else if (gnt_before != 2'b10 && m_wait < STARVE_LIMIT) m_wait = m_wait + 1;
        m_h1 = m_h0;
        m_h0 = cpu_now;
    endtask

    function automatic logic [32:0] dut_vec();
        return {GNT, MEM_ACCESS, MEM_UDS, MEM_LDS, MEM_RW, MEM_A,
                CPU_VALID, CPU_WTERM, DMA_VALID, DMA_WTERM};
    endfunction

    task automatic check(input string tag);
        logic [32:0] obs, exp;
        obs = dut_vec();
        exp = {e_gnt, e_acc, e_uds, e_lds, e_rw, e_a, e_cv, e_cw, e_dv, e_dw};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
        check(tag);
    endtask

    initial begin
        int n, m, cpu_grants, saw;
        logic [1:0] prev_gnt;
        int cpu_left, dma_left, cpu_str, dma_str;

        // Reset state
        model_reset();
        repeat (2) @(negedge CLK);
        check("reset");
        RST = 1'b1;
        repeat (2) step("idle");

        // CPU read alone
        CPU_ACCESS = 1'b0; CPU_RW = 1'b1; CPU_UDS = 1'b0; CPU_LDS = 1'b0; CPU_A = 23'h012345;
        n = 0;
        while (MEM_ACCESS !== 1'b0 && n < 10) begin step("cpu_rd"); n++; end
        check_val("cpu_rd_latency", 33'(n), 33'd4);
        check_val("cpu_rd_addr", 33'(MEM_A), 33'h012345);
        check_val("cpu_rd_gnt", 33'(GNT), 33'd1);
        MEM_VALID = 1'b0;
        step("cpu_rd_valid");
        check_val("cpu_valid_low", 33'(CPU_VALID), 33'd0);
        check_val("dma_valid_idle", 33'(DMA_VALID), 33'd1);
        MEM_VALID = 1'b1; CPU_ACCESS = 1'b1; CPU_UDS = 1'b1; CPU_LDS = 1'b1;
        n = 0;
        while (GNT !== 2'b00 && n < 10) begin step("cpu_rel"); n++; end
        check_val("cpu_rel_latency", 33'(n), 33'd3);
        check_val("cpu_rel_access", 33'(MEM_ACCESS), 33'd1);

        // DMA write with late strobes
        DMA_ACCESS = 1'b0; DMA_RW = 1'b0; DMA_UDS = 1'b1; DMA_LDS = 1'b1; DMA_A = 23'h2A5A5A;
        n = 0;
        while (GNT !== 2'b10 && n < 10) begin step("dma_wr"); n++; end
        check_val("dma_gnt", 33'(GNT), 33'd2);
        step("dma_wr");
        step("dma_wr");
        check_val("dma_strobe_pre", 33'({MEM_UDS, MEM_LDS}), 33'd3);
        DMA_UDS = 1'b0; DMA_LDS = 1'b0;
        step("dma_wr_strobe");
        check_val("dma_late_strobe", 33'({MEM_UDS, MEM_LDS, MEM_RW}), 33'd0);
        MEM_WTERM = 1'b0;
        step("dma_wterm");
        check_val("dma_wterm_low", 33'(DMA_WTERM), 33'd0);
        check_val("cpu_wterm_high", 33'(CPU_WTERM), 33'd1);
        MEM_WTERM = 1'b1; DMA_ACCESS = 1'b1; DMA_UDS = 1'b1; DMA_LDS = 1'b1; DMA_RW = 1'b1;
        step("dma_rel");
        check_val("dma_rel_gnt", 33'(GNT), 33'd0);
        repeat (GAP_CYCLES + 1) step("gap");

        // Starvation: CPU re-requests back-to-back while DMA waits
        CPU_ACCESS = 1'b0; CPU_RW = 1'b1; CPU_UDS = 1'b0; CPU_LDS = 1'b0; CPU_A = 23'h0ABCDE;
        n = 0;
        while (GNT !== 2'b01 && n < 10) begin step("starve_cpu"); n++; end
        DMA_ACCESS = 1'b0; DMA_RW = 1'b1; DMA_UDS = 1'b0; DMA_LDS = 1'b0; DMA_A = 23'h055555;
        cpu_grants = 0;
        n = 0;
        while (GNT !== 2'b10 && n < 200) begin
            if (GNT == 2'b01 && MEM_ACCESS == 1'b0) CPU_ACCESS = 1'b1;
            else if (GNT == 2'b00 && CPU_ACCESS == 1'b1) CPU_ACCESS = 1'b0;
            prev_gnt = GNT;
            step("starve");
            if (GNT == 2'b01 && prev_gnt != 2'b01) cpu_grants++;
            n++;
        end
        check_val("starve_dma_gnt", 33'(GNT), 33'd2);
        check_val("starve_cpu_grants", 33'(cpu_grants), 33'd1);
        check_val("starve_dma_addr", 33'(MEM_A), 33'h055555);
        CPU_ACCESS = 1'b1; CPU_UDS = 1'b1; CPU_LDS = 1'b1;
        step("starve_hold");
        DMA_ACCESS = 1'b1; DMA_UDS = 1'b1; DMA_LDS = 1'b1;
        n = 0;
        while (GNT !== 2'b00 && n < 10) begin step("starve_rel"); n++; end

        // CPU abort with DMA pending
        CPU_ACCESS = 1'b0; CPU_UDS = 1'b0; CPU_LDS = 1'b0; CPU_A = 23'h001111;
        n = 0;
        while (GNT !== 2'b01 && n < 20) begin step("abort_req"); n++; end
        CPU_ACCESS = 1'b1; CPU_UDS = 1'b1; CPU_LDS = 1'b1;
        DMA_ACCESS = 1'b0; DMA_RW = 1'b1; DMA_UDS = 1'b0; DMA_LDS = 1'b0; DMA_A = 23'h7FFFFF;
        saw = 0;
        n = 0;
        while (GNT !== 2'b00 && n < 10) begin
            step("abort");
            if (CPU_VALID !== 1'b1 || CPU_WTERM !== 1'b1) saw = 1;
            n++;
        end
        m = 0;
        while (GNT !== 2'b10 && m < 10) begin step("abort_dma"); m++; end
        check_val("abort_no_ack", 33'(saw), 33'd0);
        check_val("abort_to_dma", 33'(m), 33'(GAP_CYCLES + 1));

        // Asynchronous reset in the middle of a DMA grant with valid asserted
        MEM_VALID = 1'b0;
        step("rst_pre");
        check_val("rst_pre_valid", 33'(DMA_VALID), 33'd0);
        #2 RST = 1'b0;
        #1 check_val("rst_async", dut_vec(), {2'b00, 4'hF, 23'd0, 4'hF});
        model_reset();
        MEM_VALID = 1'b1;
        #1 RST = 1'b1;
        step("post_rst");
        check_val("post_rst_gnt", 33'(GNT), 33'd2);
        DMA_ACCESS = 1'b1; DMA_UDS = 1'b1; DMA_LDS = 1'b1;
        repeat (GAP_CYCLES + 3) step("post_rst_rel");

        // Randomized traffic on both ports against the model
        cpu_left = 0; dma_left = 0; cpu_str = 0; dma_str = 0;
        for (int c = 0; c < 4000; c++) begin
            if (cpu_left == 0) begin
                if (CPU_ACCESS) begin
                    CPU_ACCESS = 1'b0; CPU_RW = 1'($urandom_range(0, 1)); CPU_A = 23'($urandom);
                    cpu_str = $urandom_range(0, 3); cpu_left = $urandom_range(1, 16);
                end else begin
                    CPU_ACCESS = 1'b1; CPU_UDS = 1'b1; CPU_LDS = 1'b1;
                    cpu_left = $urandom_range(0, 5);
                end
            end else cpu_left--;
            if (!CPU_ACCESS) begin
                if (cpu_str == 0) {CPU_UDS, CPU_LDS} = 2'($urandom_range(0, 2));
                else cpu_str--;
            end
            if (dma_left == 0) begin
                if (DMA_ACCESS) begin
                    DMA_ACCESS = 1'b0; DMA_RW = 1'($urandom_range(0, 1)); DMA_A = 23'($urandom);
                    dma_str = $urandom_range(0, 3); dma_left = $urandom_range(1, 24);
                end else begin
                    DMA_ACCESS = 1'b1; DMA_UDS = 1'b1; DMA_LDS = 1'b1;
                    dma_left = $urandom_range(0, 8);
                end
            end else dma_left--;
            if (!DMA_ACCESS) begin
                if (dma_str == 0) {DMA_UDS, DMA_LDS} = 2'($urandom_range(0, 2));
                else dma_str--;
            end
            MEM_VALID = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            MEM_WTERM = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
